duty_button_conditioner: RTL and testbench

//  Upstream stage of the PWM generator: conditions the two raw duty-cycle push buttons.

---
 rtl/duty_button_conditioner.sv | 208 ++++++++++++++++++++
 tb/tb_duty_button_conditioner.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_button_conditioner.sv
// duty_button_conditioner
//   Conditions the two raw duty-cycle push buttons feeding the PWM duty-cycle
//   update logic: two-FF synchroniser per button, debounce evaluated on a slow
//   sample tick, and registered single-cycle inc/dec request pulses.
//   Optional hold-to-repeat is compiled in with the AUTO_REPEAT_EN macro; when
//   the macro is undefined each debounced press yields exactly one pulse.
//
// Parameters
//   TICK_DIV       clk cycles per sample tick (>=1)
//   DEBOUNCE_TICKS consecutive differing ticks needed to change a level (>=1)
//   REPEAT_DELAY   ticks from press pulse to first repeat pulse (AUTO_REPEAT_EN)
//   REPEAT_RATE    ticks between later repeat pulses (AUTO_REPEAT_EN)
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn_inc_raw  in   raw increase button, asynchronous, active high
//   btn_dec_raw  in   raw decrease button, asynchronous, active high
//   inc_pulse    out  one-cycle increase-duty request
//   dec_pulse    out  one-cycle decrease-duty request
//   inc_level    out  debounced increase button level
//   dec_level    out  debounced decrease button level
//   sample_tick  out  one-cycle sample strobe
module duty_button_conditioner #(
   parameter int unsigned TICK_DIV       = 250000,
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter int unsigned REPEAT_DELAY   = 20,
   parameter int unsigned REPEAT_RATE    = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_inc_raw,
   input  logic btn_dec_raw,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic inc_level,
   output logic dec_level,
   output logic sample_tick
);

   localparam int unsigned PW = $clog2(TICK_DIV) + 1;
   localparam int unsigned DW = $clog2(DEBOUNCE_TICKS) + 1;
`ifdef AUTO_REPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW   = $clog2(RMAX) + 1;

   typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;
`endif

   logic [PW-1:0] pre_cnt;
   logic [PW-1:0] pre_nxt;
   logic          tick;
   logic [1:0]    raw;
   logic [1:0]    level;
   logic [1:0]    level_nxt;
   logic [1:0]    req;
   logic          both_held;

   // Prescaler; tick is registered so it is high exactly while the count
   // sits at TICK_DIV-1 and is 0 during reset.
   always_comb begin
      pre_nxt = (pre_cnt == PW'(TICK_DIV - 1)) ? '0 : pre_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         pre_cnt <= pre_nxt;
         tick    <= (pre_nxt == PW'(TICK_DIV - 1));
      end
   end

   assign sample_tick = tick;
   assign raw         = {btn_dec_raw, btn_inc_raw};

   // Index 0 = increase button, index 1 = decrease button.
   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic          s1;
      logic          s2;
      logic          lvl;
      logic          lvl_nxt;
      logic          rise;
      logic [DW-1:0] cnt;
      logic [DW-1:0] cnt_nxt;

      always_comb begin
         lvl_nxt = lvl;
         cnt_nxt = cnt;
         rise    = 1'b0;
         if (tick) begin
            if (s2 == lvl) begin
               cnt_nxt = '0;
            end else if (cnt == DW'(DEBOUNCE_TICKS - 1)) begin
               lvl_nxt = s2;
               cnt_nxt = '0;
               rise    = s2;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            lvl <= 1'b0;
            cnt <= '0;
         end else begin
            s1  <= raw[b];
            s2  <= s1;
            lvl <= lvl_nxt;
            cnt <= cnt_nxt;
         end
      end

      assign level[b]     = lvl;
      assign level_nxt[b] = lvl_nxt;

`ifdef AUTO_REPEAT_EN
      rpt_state_t    st;
      rpt_state_t    st_nxt;
      logic [RW-1:0] rc;
      logic [RW-1:0] rc_nxt;
      logic          rpt;

      // Leaving on the falling level edge (lvl_nxt==0) returns to IDLE in the
      // same cycle the level drops, so no repeat can fire on that cycle.
      always_comb begin
         st_nxt = st;
         rc_nxt = rc;
         rpt    = 1'b0;
         if (!lvl_nxt) begin
            st_nxt = RPT_IDLE;
            rc_nxt = '0;
         end else begin
            case (st)
               RPT_IDLE: begin
                  if (rise) begin
                     st_nxt = RPT_DELAY;
                     rc_nxt = '0;
                  end
               end
               RPT_DELAY: begin
                  if (tick) begin
                     if (rc == RW'(REPEAT_DELAY - 1)) begin
                        st_nxt = RPT_REPEAT;
                        rc_nxt = '0;
                        rpt    = 1'b1;
                     end else if (rc != '1) begin
                        rc_nxt = rc + 1'b1;
                     end
                  end
               end
               RPT_REPEAT: begin
                  if (tick) begin
                     if (rc == RW'(REPEAT_RATE - 1)) begin
                        rc_nxt = '0;
                        rpt    = 1'b1;
                     end else if (rc != '1) begin
                        rc_nxt = rc + 1'b1;
                     end
                  end
               end
               default: begin
                  st_nxt = RPT_IDLE;
                  rc_nxt = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st <= RPT_IDLE;
            rc <= '0;
         end else begin
            st <= st_nxt;
            rc <= rc_nxt;
         end
      end

      assign req[b] = rise | rpt;
`else
      assign req[b] = rise;
`endif
   end

   // Suppression uses the levels as they will read alongside the pulse, so a
   // press that completes the both-held condition is itself suppressed.
   assign both_held = &level_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inc_pulse <= 1'b0;
         dec_pulse <= 1'b0;
      end else begin
         inc_pulse <= req[0] & ~req[1] & ~both_held;
         dec_pulse <= req[1] & ~req[0] & ~both_held;
      end
   end

   assign inc_level = level[0];
   assign dec_level = level[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
module tb_duty_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 3;
   localparam int RR = 2;
`ifdef AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic a_inc, a_dec, b_inc, b_dec;
   logic a_inc_pulse, a_dec_pulse, a_inc_level, a_dec_level, a_tick;
   logic b_inc_pulse, b_dec_pulse, b_inc_level, b_dec_level, b_tick;
   logic [4:0] a_vec, b_vec;

   int tests;
   int failed;
   int cyc;

   duty_button_conditioner #(.TICK_DIV(1), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_a (
      .clk(clk), .rst_n(rst_n), .btn_inc_raw(a_inc), .btn_dec_raw(a_dec),
      .inc_pulse(a_inc_pulse), .dec_pulse(a_dec_pulse), .inc_level(a_inc_level),
      .dec_level(a_dec_level), .sample_tick(a_tick));

   duty_button_conditioner #(.TICK_DIV(5), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_b (
      .clk(clk), .rst_n(rst_n), .btn_inc_raw(b_inc), .btn_dec_raw(b_dec),
      .inc_pulse(b_inc_pulse), .dec_pulse(b_dec_pulse), .inc_level(b_inc_level),
      .dec_level(b_dec_level), .sample_tick(b_tick));

   assign a_vec = {a_inc_pulse, a_dec_pulse, a_inc_level, a_dec_level, a_tick};
   assign b_vec = {b_inc_pulse, b_dec_pulse, b_inc_level, b_dec_level, b_tick};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   // Edge count since reset gives the tick phase arithmetically; the synchroniser
   // is a two-deep history queue; debounce is a streak of differing ticks;
   // repeats follow from the number of ticks elapsed since the press.
   int m_e[2];
   bit m_lvl[2][2];
   bit m_pul[2][2];
   int m_streak[2][2];
   int m_since[2][2];
   bit m_hist[2][2][$];
   bit nl[2];
   bit rq[2];
   bit s2v;

   function automatic bit tickf(int d, int e);
      int td;
      td = (d == 0) ? 1 : 5;
      return (e >= 1) && ((e % td) == td - 1);
   endfunction

   function automatic bit rawf(int d, int b);
      if (d == 0) return (b == 0) ? a_inc : a_dec;
      return (b == 0) ? b_inc : b_dec;
   endfunction

   function automatic logic [4:0] exp_vec(int d);
      return {m_pul[d][0], m_pul[d][1], m_lvl[d][0], m_lvl[d][1], tickf(d, m_e[d])};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_e[d] = 0;
            for (int b = 0; b < 2; b++) begin
               m_lvl[d][b] = 1'b0;
               m_pul[d][b] = 1'b0;
               m_streak[d][b] = 0;
               m_since[d][b] = 0;
               m_hist[d][b].delete();
            end
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 2; b++) begin
               s2v = (m_hist[d][b].size() == 2) ? m_hist[d][b][0] : 1'b0;
               m_hist[d][b].push_back(rawf(d, b));
               if (m_hist[d][b].size() > 2) void'(m_hist[d][b].pop_front());
               nl[b] = m_lvl[d][b];
               rq[b] = 1'b0;
               if (tickf(d, m_e[d])) begin
                  if (s2v != m_lvl[d][b]) begin
                     m_streak[d][b]++;
                     if (m_streak[d][b] == DB) begin
                        nl[b] = s2v;
                        m_streak[d][b] = 0;
                        if (s2v) begin
                           rq[b] = 1'b1;
                           m_since[d][b] = 0;
                        end
                     end
                  end else begin
                     m_streak[d][b] = 0;
                  end
                  if (REP && m_lvl[d][b] && nl[b]) begin
                     m_since[d][b]++;
                     if (m_since[d][b] == RD || (m_since[d][b] > RD && ((m_since[d][b] - RD) % RR) == 0))
                        rq[b] = 1'b1;
                  end
               end
            end
            m_pul[d][0] = rq[0] && !rq[1] && !(nl[0] && nl[1]);
            m_pul[d][1] = rq[1] && !rq[0] && !(nl[0] && nl[1]);
            m_lvl[d][0] = nl[0];
            m_lvl[d][1] = nl[1];
            m_e[d]++;
         end
      end
   end

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      // reset state
      #2;
      tests++;
      if ({a_vec, b_vec} !== 10'b0) begin
         failed++;
         $display("FAIL reset_state got=%b exp=%b", {a_vec, b_vec}, 10'b0);
      end
      idle(2);
      rst_n = 1'b1;
      idle(3);
      // raise inc, let it debounce, then reset asynchronously mid-press
      a_inc = 1'b1;
      idle(9);
      tests++;
      if (a_vec !== exp_vec(0)) begin
         failed++;
         $display("FAIL pre_reset_model cyc=%0d got=%b exp=%b", cyc, a_vec, exp_vec(0));
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({a_vec, b_vec} !== 10'b0) begin
         failed++;
         $display("FAIL async_reset got=%b exp=%b", {a_vec, b_vec}, 10'b0);
      end
      idle(2);
      rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         tests++;
         if (a_inc_pulse !== ((k == 6) || (REP && k == 9))) begin
            failed++;
            $display("FAIL reset_press_pulse k=%0d got=%b exp=%b", k, a_inc_pulse, (k == 6) || (REP && k == 9));
         end
         tests++;
         if (a_inc_level !== (k >= 6)) begin
            failed++;
            $display("FAIL reset_press_level k=%0d got=%b exp=%b", k, a_inc_level, k >= 6);
         end
         tests++;
         if (a_vec !== exp_vec(0)) begin
            failed++;
            $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, a_vec, exp_vec(0));
         end
      end
      a_inc = 1'b0;
      idle(12);
   endtask

   task automatic test_clean_press;
      a_inc = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         tests++;
         if (a_inc_pulse !== ((k == 6) || (REP && k == 9)) || a_dec_pulse !== 1'b0) begin
            failed++;
            $display("FAIL clean_press k=%0d got inc=%b dec=%b", k, a_inc_pulse, a_dec_pulse);
         end
         tests++;
         if (a_vec !== exp_vec(0)) begin
            failed++;
            $display("FAIL clean_model cyc=%0d got=%b exp=%b", cyc, a_vec, exp_vec(0));
         end
      end
      a_inc = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         tests++;
         if (a_inc_level !== (k < 6)) begin
            failed++;
            $display("FAIL release_level k=%0d got=%b exp=%b", k, a_inc_level, k < 6);
         end
         tests++;
         if (a_inc_pulse !== (REP && (k == 1 || k == 3 || k == 5))) begin
            failed++;
            $display("FAIL release_pulse k=%0d got=%b exp=%b", k, a_inc_pulse, REP && (k == 1 || k == 3 || k == 5));
         end
      end
      idle(5);
   endtask

   task automatic test_bounce;
      for (int k = 0; k < 4; k++) begin
         a_dec = (k % 2 == 0);
         @(negedge clk);
         tests++;
         if (a_dec_pulse !== 1'b0 || a_dec_level !== 1'b0) begin
            failed++;
            $display("FAIL bounce_toggle k=%0d got pulse=%b level=%b exp=0", k, a_dec_pulse, a_dec_level);
         end
      end
      a_dec = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         tests++;
         if (a_dec_pulse !== ((k == 6) || (REP && k == 9))) begin
            failed++;
            $display("FAIL bounce_pulse k=%0d got=%b exp=%b", k, a_dec_pulse, (k == 6) || (REP && k == 9));
         end
         tests++;
         if (a_vec !== exp_vec(0)) begin
            failed++;
            $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, a_vec, exp_vec(0));
         end
      end
      a_dec = 1'b0;
      idle(12);
   endtask

   task automatic test_simultaneous;
      a_inc = 1'b1;
      a_dec = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         if (k == 16) begin
            a_inc = 1'b0;
            a_dec = 1'b0;
         end
         @(negedge clk);
         tests++;
         if (a_inc_pulse !== 1'b0 || a_dec_pulse !== 1'b0) begin
            failed++;
            $display("FAIL simul_pulse k=%0d got inc=%b dec=%b exp=0", k, a_inc_pulse, a_dec_pulse);
         end
         if (k >= 6 && k <= 15) begin
            tests++;
            if ({a_inc_level, a_dec_level} !== 2'b11) begin
               failed++;
               $display("FAIL simul_level k=%0d got=%b exp=11", k, {a_inc_level, a_dec_level});
            end
         end
      end
      idle(5);
   endtask

   task automatic test_repeat;
      bit ex;
      a_inc = 1'b1;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         ex = (k == 6) || (REP && k >= 9 && k <= 25 && ((k - 9) % 2) == 0);
         tests++;
         if (a_inc_pulse !== ex || a_dec_pulse !== 1'b0) begin
            failed++;
            $display("FAIL repeat_pulse k=%0d got inc=%b dec=%b exp inc=%b", k, a_inc_pulse, a_dec_pulse, ex);
         end
         tests++;
         if (a_vec !== exp_vec(0)) begin
            failed++;
            $display("FAIL repeat_model cyc=%0d got=%b exp=%b", cyc, a_vec, exp_vec(0));
         end
         if (k == 20) a_inc = 1'b0;
      end
   endtask

   task automatic test_prescaler;
      int ticks, pulses, first_k;
      bit prev_tick;
      ticks = 0;
      pulses = 0;
      first_k = 0;
      prev_tick = b_tick;
      b_inc = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         tests++;
         if (b_vec !== exp_vec(1)) begin
            failed++;
            $display("FAIL presc_model cyc=%0d got=%b exp=%b", cyc, b_vec, exp_vec(1));
         end
         if (k <= 25 && b_tick) ticks++;
         if (b_inc_pulse) begin
            pulses++;
            if (first_k == 0) first_k = k;
            tests++;
            if (prev_tick !== 1'b1) begin
               failed++;
               $display("FAIL presc_pulse_on_tick k=%0d got prev_tick=%b exp=1", k, prev_tick);
            end
         end
         prev_tick = b_tick;
      end
      tests++;
      if (ticks != 5) begin
         failed++;
         $display("FAIL presc_tick_count got=%0d exp=5", ticks);
      end
      tests++;
      if (pulses != 1 || first_k < 18 || first_k > 22) begin
         failed++;
         $display("FAIL presc_latency got pulses=%0d first=%0d exp pulses=1 first in 18..22", pulses, first_k);
      end
      b_inc = 1'b0;
      idle(40);
   endtask

   task automatic test_random;
      int hold[4];
      bit v;
      for (int i = 0; i < 4; i++) hold[i] = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         tests++;
         if (a_vec !== exp_vec(0)) begin
            failed++;
            $display("FAIL random_a cyc=%0d got=%b exp=%b", cyc, a_vec, exp_vec(0));
         end
         tests++;
         if (b_vec !== exp_vec(1)) begin
            failed++;
            $display("FAIL random_b cyc=%0d got=%b exp=%b", cyc, b_vec, exp_vec(1));
         end
         tests++;
         if ((a_inc_pulse && a_dec_pulse) || (b_inc_pulse && b_dec_pulse)) begin
            failed++;
            $display("FAIL random_mutex cyc=%0d got a=%b%b b=%b%b", cyc, a_inc_pulse, a_dec_pulse, b_inc_pulse, b_dec_pulse);
         end
         for (int i = 0; i < 4; i++) begin
            if (hold[i] == 0) begin
               v = 1'(($urandom_range(0, 1)));
               hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 6);
               case (i)
                  0: a_inc = v;
                  1: a_dec = v;
                  2: b_inc = v;
                  default: b_dec = v;
               endcase
            end else begin
               hold[i]--;
            end
         end
      end
      a_inc = 1'b0;
      a_dec = 1'b0;
      b_inc = 1'b0;
      b_dec = 1'b0;
   endtask

   initial begin
      tests = 0;
      failed = 0;
      cyc = 0;
      rst_n = 1'b0;
      a_inc = 1'b0;
      a_dec = 1'b0;
      b_inc = 1'b0;
      b_dec = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_repeat();
      test_prescaler();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
